fc_weight_sequencer: RTL and testbench

//  Address sequencer for a dual-port fully-connected weight ROM (9-bit address, 16-bit words, registered q).

---
 rtl/fc_pkg.sv | 26 ++
 rtl/fc_weight_sequencer_if.sv | 30 +++
 rtl/fc_seq_fifo.sv | 45 ++++
 rtl/fc_weight_sequencer.sv | 175 +++++++++++++++++
 tb/tb_fc_weight_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fc_pkg.sv
// Shared types for the FC weight sequencer: FSM states, ROM geometry and the per-beat flag set.
// FC_SEQ_BIAS_EN adds the is_bias flag to every beat.
package fc_pkg;

  localparam int FC_ROM_ADDR_W = 9;
  localparam int FC_ROM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } fc_seq_state_t;

  typedef struct packed {
`ifdef FC_SEQ_BIAS_EN
    logic is_bias;
`endif
    logic b_en;
    logic last_neuron;
    logic last_layer;
  } fc_seq_flags_t;

  localparam int FC_SEQ_FLAG_W = $bits(fc_seq_flags_t);

endpackage

// File: rtl/fc_weight_sequencer_if.sv
// Weight-pair stream from the sequencer (master) to the FC MAC array (slave).
// is_bias exists only when FC_SEQ_BIAS_EN is defined.
interface fc_weight_sequencer_if
  import fc_pkg::*;
#(
  parameter int DATA_W = FC_ROM_DATA_W
);

  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic              w_b_en;
  logic              last_neuron;
  logic              last_layer;
`ifdef FC_SEQ_BIAS_EN
  logic              is_bias;

  modport master (output w_valid, w_a, w_b, w_b_en, last_neuron, last_layer, is_bias,
                  input  w_ready);
  modport slave  (input  w_valid, w_a, w_b, w_b_en, last_neuron, last_layer, is_bias,
                  output w_ready);
`else
  modport master (output w_valid, w_a, w_b, w_b_en, last_neuron, last_layer,
                  input  w_ready);
  modport slave  (input  w_valid, w_a, w_b, w_b_en, last_neuron, last_layer,
                  output w_ready);
`endif

endinterface

// File: rtl/fc_seq_fifo.sv
// First-word-fall-through skid FIFO holding ROM words plus beat flags.
// Storage is not reset; only the pointers are, so an empty FIFO is the reset state.
module fc_seq_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_q, rd_q;
  logic             full, do_push, do_pop;

  assign count_o = wr_q - rd_q;
  assign empty_o = (count_o == '0);
  assign full    = (count_o == (PW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so push at full is still safe.
  assign do_push = push_i & (~full | do_pop);
  assign dout_o  = mem_q[rd_q[PW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (PW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q[PW-1:0]] <= din_i;
  end

endmodule

// File: rtl/fc_weight_sequencer.sv
// Address sequencer for a dual-port FC weight ROM: walks neurons, fetches weight pairs, streams them out.
// Optional FC_SEQ_BIAS_EN appends one bias beat per neuron (address N_OUT*N_IN+o).
module fc_weight_sequencer
  import fc_pkg::*;
#(
  parameter int N_OUT      = 10,
  parameter int N_IN       = 32,
  parameter int ADDR_W     = FC_ROM_ADDR_W,
  parameter int DATA_W     = FC_ROM_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  output logic [ADDR_W-1:0]    address_a,
  output logic [ADDR_W-1:0]    address_b,
  input  logic [DATA_W-1:0]    q_a,
  input  logic [DATA_W-1:0]    q_b,
  output logic                 busy,
  output logic                 done,
  fc_weight_sequencer_if.master wbus
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int FIFO_W = 2*DATA_W + FC_SEQ_FLAG_W;
`ifdef FC_SEQ_BIAS_EN
  localparam logic BIAS_EN = 1'b1;
`else
  localparam logic BIAS_EN = 1'b0;
`endif
  localparam logic              ODD_IN    = ((N_IN % 2) == 1);
  localparam logic [ADDR_W-1:0] LAST_I    = ADDR_W'(((N_IN - 1) / 2) * 2);
  localparam logic [ADDR_W-1:0] LAST_O    = ADDR_W'(N_OUT - 1);
  localparam logic [ADDR_W-1:0] N_IN_A    = ADDR_W'(N_IN);
  localparam logic [ADDR_W-1:0] BIAS_BASE = ADDR_W'(N_OUT * N_IN);

  fc_seq_state_t     state_q, state_d;
  logic [ADDR_W-1:0] o_q, o_d, i_q, i_d, row_q, row_d;
  logic              bias_ph_q, bias_ph_d;
  logic [ADDR_W-1:0] addr_a_q, addr_b_q, nxt_a, nxt_b;
  logic              s1_q, s2_q, issue;
  fc_seq_flags_t     f1_q, f2_q, nxt_f, fo;
  logic              last_pair, neuron_end, credit_ok, valid, pop;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [FIFO_W-1:0] fifo_din, fifo_dout;
  logic [CNT_W:0]    credit;

  // In-flight beats (address stage + ROM stage) reserve FIFO slots before they arrive.
  assign credit    = {1'b0, fifo_count} + {{CNT_W{1'b0}}, s1_q} + {{CNT_W{1'b0}}, s2_q};
  assign credit_ok = (credit < (CNT_W+1)'(FIFO_DEPTH));

  always_comb begin
    nxt_f      = '0;
    last_pair  = (i_q == LAST_I);
    neuron_end = BIAS_EN ? bias_ph_q : last_pair;
    nxt_a      = row_q + i_q;
    if (bias_ph_q) nxt_a = BIAS_BASE + o_q;
    nxt_f.b_en = ~bias_ph_q & ~(ODD_IN & last_pair);
    nxt_b      = nxt_f.b_en ? nxt_a + ADDR_W'(1) : nxt_a;
    nxt_f.last_neuron = neuron_end;
    nxt_f.last_layer  = neuron_end & (o_q == LAST_O);
`ifdef FC_SEQ_BIAS_EN
    nxt_f.is_bias = bias_ph_q;
`endif
  end

  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    o_d       = o_q;
    i_d       = i_q;
    row_d     = row_q;
    bias_ph_d = bias_ph_q;
    unique case (state_q)
      IDLE: begin
        o_d       = '0;
        i_d       = '0;
        row_d     = '0;
        bias_ph_d = 1'b0;
        if (start) state_d = RUN;
      end
      RUN: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (neuron_end) begin
            o_d       = o_q + ADDR_W'(1);
            i_d       = '0;
            row_d     = row_q + N_IN_A;
            bias_ph_d = 1'b0;
            if (o_q == LAST_O) state_d = DRAIN;
          end else if (BIAS_EN && last_pair) begin
            bias_ph_d = 1'b1;
          end else begin
            i_d = i_q + ADDR_W'(2);
          end
        end
      end
      DRAIN: if (fifo_empty && !s1_q && !s2_q) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Stage 1: address register. Stage 2: ROM output register. FIFO write follows.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      o_q       <= '0;
      i_q       <= '0;
      row_q     <= '0;
      bias_ph_q <= 1'b0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      f1_q      <= '0;
      f2_q      <= '0;
    end else begin
      o_q       <= o_d;
      i_q       <= i_d;
      row_q     <= row_d;
      bias_ph_q <= bias_ph_d;
      s1_q      <= issue;
      s2_q      <= s1_q;
      if (issue) begin
        addr_a_q <= nxt_a;
        addr_b_q <= nxt_b;
        f1_q     <= nxt_f;
      end
      f2_q <= f1_q;
    end
  end

  assign fifo_din = {f2_q, q_a, (f2_q.b_en ? q_b : {DATA_W{1'b0}})};

  fc_seq_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (s2_q),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign valid = ~fifo_empty;
  assign pop   = valid & wbus.w_ready;
  assign fo    = fifo_dout[FIFO_W-1 -: FC_SEQ_FLAG_W];

  // Outputs are masked while empty so unreset FIFO storage never leaks out.
  assign wbus.w_valid     = valid;
  assign wbus.w_a         = valid ? fifo_dout[2*DATA_W-1 -: DATA_W] : '0;
  assign wbus.w_b         = valid ? fifo_dout[DATA_W-1:0] : '0;
  assign wbus.w_b_en      = valid & fo.b_en;
  assign wbus.last_neuron = valid & fo.last_neuron;
  assign wbus.last_layer  = valid & fo.last_layer;
`ifdef FC_SEQ_BIAS_EN
  assign wbus.is_bias     = valid & fo.is_bias;
`endif

  assign address_a = addr_a_q;
  assign address_b = addr_b_q;
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_fc_weight_sequencer.sv
// Bench for fc_weight_sequencer: default 10x32 instance with a beat-list reference model and random
// backpressure, plus a 2x5 instance checked against a constant table. Honours FC_SEQ_BIAS_EN.
module tb_fc_weight_sequencer;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        en;
    logic        ln;
    logic        ll;
    logic        bi;
  } beat_t;

  typedef struct {
    int    stall;
    beat_t exp;
  } vec_t;

`ifdef FC_SEQ_BIAS_EN
  localparam bit BIAS = 1'b1;
`else
  localparam bit BIAS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start1 = 1'b0, start2 = 1'b0;
  logic [8:0]  aa1, ab1, aa2, ab2;
  logic [15:0] qa1, qb1, qa2, qb2;
  logic        busy1, done1, busy2, done2;
  int          total = 0;
  int          bad = 0;
  beat_t       exp_q[$];

  fc_weight_sequencer_if #(.DATA_W(16)) bus1 ();
  fc_weight_sequencer_if #(.DATA_W(16)) bus2 ();

  fc_weight_sequencer dut1 (
    .clock(clk), .reset_n(rst_n), .start(start1),
    .address_a(aa1), .address_b(ab1), .q_a(qa1), .q_b(qb1),
    .busy(busy1), .done(done1), .wbus(bus1)
  );

  fc_weight_sequencer #(.N_OUT(2), .N_IN(5)) dut2 (
    .clock(clk), .reset_n(rst_n), .start(start2),
    .address_a(aa2), .address_b(ab2), .q_a(qa2), .q_b(qb2),
    .busy(busy2), .done(done2), .wbus(bus2)
  );

  always #5 clk = ~clk;

  // ROM model: word = address, registered output
  always @(posedge clk) begin
    qa1 <= {7'd0, aa1};
    qb1 <= {7'd0, ab1};
    qa2 <= {7'd0, aa2};
    qb2 <= {7'd0, ab2};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic beat_t samp1();
    beat_t b;
    b.a  = bus1.w_a;
    b.b  = bus1.w_b;
    b.en = bus1.w_b_en;
    b.ln = bus1.last_neuron;
    b.ll = bus1.last_layer;
`ifdef FC_SEQ_BIAS_EN
    b.bi = bus1.is_bias;
`else
    b.bi = 1'b0;
`endif
    return b;
  endfunction

  function automatic beat_t samp2();
    beat_t b;
    b.a  = bus2.w_a;
    b.b  = bus2.w_b;
    b.en = bus2.w_b_en;
    b.ln = bus2.last_neuron;
    b.ll = bus2.last_layer;
`ifdef FC_SEQ_BIAS_EN
    b.bi = bus2.is_bias;
`else
    b.bi = 1'b0;
`endif
    return b;
  endfunction

  function automatic logic [63:0] outs1();
    return {7'd0, aa1, ab1, bus1.w_valid, samp1(), busy1, done1};
  endfunction

  function automatic logic [63:0] outs2();
    return {7'd0, aa2, ab2, bus2.w_valid, samp2(), busy2, done2};
  endfunction

  // Reference: list every beat of a pass straight from the weight/bias layout.
  task automatic build_model(input int no, input int ni);
    beat_t b;
    exp_q.delete();
    for (int o = 0; o < no; o++) begin
      for (int i = 0; i < ni; i += 2) begin
        b.a  = 16'(o*ni + i);
        b.en = (i + 1 < ni);
        b.b  = b.en ? 16'(o*ni + i + 1) : 16'd0;
        b.ln = (i + 2 >= ni) && !BIAS;
        b.ll = b.ln && (o == no - 1);
        b.bi = 1'b0;
        exp_q.push_back(b);
      end
      if (BIAS) begin
        b.a  = 16'(no*ni + o);
        b.b  = 16'd0;
        b.en = 1'b0;
        b.ln = 1'b1;
        b.ll = (o == no - 1);
        b.bi = 1'b1;
        exp_q.push_back(b);
      end
    end
  endtask

  // mode 0: w_ready held high; mode 1: random w_ready. restart_beat>=0 pulses start mid-pass.
  task automatic run_pass(input int mode, input int restart_beat, input string nm);
    int    k, c, first_c, last_c, done_c, dones;
    bit    prev_stall, restarted, busy_first;
    beat_t cur, prev;
    build_model(10, 32);
    k = 0; c = 0; first_c = -1; last_c = -1; done_c = -1; dones = 0;
    prev_stall = 0; restarted = 0; busy_first = 0; prev = '0;
    bus1.w_ready = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    while (c < 3000 && !(dones > 0 && c >= done_c + 3)) begin
      @(negedge clk);
      c++;
      cur = samp1();
      if (prev_stall) chk({nm, "_hold"}, {bus1.w_valid, cur}, {1'b1, prev});
      bus1.w_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 55);
      start1 = 1'b0;
      if (restart_beat >= 0 && k == restart_beat && !restarted) begin
        start1 = 1'b1;
        restarted = 1;
      end
      if (bus1.w_valid && first_c < 0) begin
        first_c = c;
        busy_first = busy1;
      end
      if (done1) begin
        dones++;
        done_c = c;
        start1 = 1'b1;
      end
      if (bus1.w_valid && bus1.w_ready) begin
        if (k < exp_q.size()) chk($sformatf("%s_beat%0d", nm, k), cur, exp_q[k]);
        else chk({nm, "_extra_beat"}, k, exp_q.size());
        k++;
        last_c = c;
      end
      prev_stall = bus1.w_valid && !bus1.w_ready;
      prev = cur;
    end
    start1 = 1'b0;
    bus1.w_ready = 1'b0;
    chk({nm, "_beats"}, k, exp_q.size());
    chk({nm, "_dones"}, dones, 1);
    chk({nm, "_done_lat"}, done_c - last_c, 2);
    chk({nm, "_busy_run"}, busy_first, 1);
    chk({nm, "_idle_after"}, {busy1, done1}, 2'b00);
    if (mode == 0) begin
      chk({nm, "_first_valid"}, first_c, 3);
      chk({nm, "_last_beat"}, last_c, 2 + exp_q.size());
    end
    @(negedge clk);
  endtask

  function automatic vec_t mk(input int stall, input int a, input int b,
                              input bit en, input bit ln, input bit ll, input bit bi);
    vec_t v;
    v.stall  = stall;
    v.exp.a  = 16'(a);
    v.exp.b  = 16'(b);
    v.exp.en = en;
    v.exp.ln = ln;
    v.exp.ll = ll;
    v.exp.bi = bi;
    return v;
  endfunction

  task automatic table_test();
    vec_t tbl[8];
    int   n, g;
`ifdef FC_SEQ_BIAS_EN
    n = 8;
    tbl[0] = mk(0, 0, 1, 1, 0, 0, 0);
    tbl[1] = mk(2, 2, 3, 1, 0, 0, 0);
    tbl[2] = mk(0, 4, 0, 0, 0, 0, 0);
    tbl[3] = mk(1, 10, 0, 0, 1, 0, 1);
    tbl[4] = mk(3, 5, 6, 1, 0, 0, 0);
    tbl[5] = mk(0, 7, 8, 1, 0, 0, 0);
    tbl[6] = mk(2, 9, 0, 0, 0, 0, 0);
    tbl[7] = mk(0, 11, 0, 0, 1, 1, 1);
`else
    n = 6;
    tbl[0] = mk(0, 0, 1, 1, 0, 0, 0);
    tbl[1] = mk(2, 2, 3, 1, 0, 0, 0);
    tbl[2] = mk(0, 4, 0, 0, 1, 0, 0);
    tbl[3] = mk(1, 5, 6, 1, 0, 0, 0);
    tbl[4] = mk(3, 7, 8, 1, 0, 0, 0);
    tbl[5] = mk(0, 9, 0, 0, 1, 1, 0);
    tbl[6] = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[7] = mk(0, 0, 0, 0, 0, 0, 0);
`endif
    bus2.w_ready = 1'b0;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int j = 0; j < n; j++) begin
      bus2.w_ready = 1'b0;
      repeat (tbl[j].stall) @(negedge clk);
      bus2.w_ready = 1'b1;
      g = 0;
      while (!bus2.w_valid && g < 50) begin
        @(negedge clk);
        g++;
      end
      chk($sformatf("t3_wait%0d", j), (g < 50), 1'b1);
      chk($sformatf("t3_beat%0d", j), samp2(), tbl[j].exp);
      @(negedge clk);
    end
    bus2.w_ready = 1'b0;
    g = 0;
    while (!done2 && g < 10) begin
      @(negedge clk);
      g++;
    end
    chk("t3_done_lat", g, 1);
    chk("t3_tail", {bus2.w_valid, busy2}, 2'b00);
    @(negedge clk);
  endtask

  task automatic abort_test();
    int n, c, dsum;
    bus1.w_ready = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0; c = 0;
    while (n < 50 && c < 500) begin
      @(negedge clk);
      c++;
      if (bus1.w_valid) n++;
    end
    chk("t4_reach50", n, 50);
    bus1.w_ready = 1'b0;
    @(negedge clk);
    chk("t4_stalled", {bus1.w_valid, busy1}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_outs_zero", outs1(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dsum = 0;
    repeat (4) begin
      @(negedge clk);
      dsum += done1;
    end
    chk("t4_no_done", dsum, 0);
    chk("t4_idle", {busy1, bus1.w_valid}, 2'b00);
  endtask

  initial begin
    bus1.w_ready = 1'b0;
    bus2.w_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs1", outs1(), 64'd0);
    chk("reset_outs2", outs2(), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_pass(0, -1, "t1");
    run_pass(1, -1, "t2");
    run_pass(0, 20, "t5");
    table_test();
    abort_test();
    run_pass(0, -1, "t4_rerun");
    run_pass(1, 20, "t2b");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
